rst_seq: RTL and testbench

Reset sequencer that releases `N_DOMAIN` downstream reset domains in a fixed order (domain 0 first). Each stage waits for the previous domain's ready handshake, then a programmable delay. On a soft-reset request it re-asserts the domains in reverse order. It sits after the top-level reset synchronisers, and its `rst_n_o` bits feed the per-domain reset inputs of the datapath blocks.

---
 rtl/rst_seq_pkg.sv | 23 ++
 rtl/rst_seq_cnt_dn.sv | 29 ++
 rtl/rst_seq.sv | 163 ++++++++++++++++
 tb/tb_rst_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package rst_seq_pkg;

   typedef enum logic [2:0] {
      ST_HOLD   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_DELAY  = 3'd2,
      ST_RUN    = 3'd3,
      ST_ASSERT = 3'd4
   } state_e;

   // Counter must hold the largest of the hold, delay and timeout loads.
   function automatic int unsigned cnt_width(input int unsigned h,
                                             input int unsigned d,
                                             input int unsigned t);
      int unsigned m;
      m = h;
      if (d > m) m = d;
      if (t > m) m = t;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/rst_seq_cnt_dn.sv
// Loadable down-counter; exp_o flags the final count (value 1).
module cnt_dn #(
   parameter int unsigned W       = 8,
   parameter int unsigned RST_VAL = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic         en_i,
   input  logic [W-1:0] val_i,
   output logic         exp_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)                  cnt_d = val_i;
      else if (en_i && cnt_q != '0) cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= W'(RST_VAL);
      else       cnt_q <= cnt_d;
   end

   assign exp_o = (cnt_q == W'(1));

endmodule

// File: rtl/rst_seq.sv
// Ordered release / reverse re-assertion of N_DOMAIN reset domains.
// Optional ready-wait timeout with sticky err_o when RST_SEQ_TIMEOUT_EN is defined.
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int unsigned N_DOMAIN  = 4,
   parameter int unsigned H_HOLD    = 8,
   parameter int unsigned D_DELAY   = 16,
   parameter int unsigned T_TIMEOUT = 1024
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        req_i,
   input  logic [N_DOMAIN-1:0]         rdy_i,
   output logic [N_DOMAIN-1:0]         rst_n_o,
   output logic                        done_o,
   output logic [$clog2(N_DOMAIN)-1:0] stage_o,
   output logic                        err_o
);

   localparam int unsigned CNT_W = cnt_width(H_HOLD, D_DELAY, T_TIMEOUT);
   localparam int unsigned STG_W = $clog2(N_DOMAIN);
   localparam logic [STG_W-1:0] LAST = STG_W'(N_DOMAIN - 1);

   state_e              state_q, state_d;
   logic [N_DOMAIN-1:0] rst_n_q, rst_n_d, rst_n_clr;
   logic [STG_W-1:0]    stage_q, stage_d, top_idx, stage_nxt;
   logic                done_q, done_d;
   logic                skip_q, skip_d;
   logic                cnt_load, cnt_en, cnt_exp;
   logic [CNT_W-1:0]    cnt_val;
   logic                tmo_hit, hold_exp, adv, is_last;

   // The first cycle after reset does not count, so release lands H_HOLD edges later.
   assign hold_exp  = cnt_exp & ~skip_q;
   assign adv       = rdy_i[stage_q] | tmo_hit;
   assign is_last   = (stage_q == LAST);
   assign stage_nxt = stage_q + STG_W'(1);

   cnt_dn #(.W(CNT_W), .RST_VAL(H_HOLD)) u_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (cnt_load),
      .en_i   (cnt_en),
      .val_i  (cnt_val),
      .exp_o  (cnt_exp)
   );

   // Highest released domain, and the mask with it re-asserted.
   always_comb begin
      top_idx = '0;
      for (int unsigned i = 0; i < N_DOMAIN; i++) begin
         if (rst_n_q[i]) top_idx = STG_W'(i);
      end
      rst_n_clr          = rst_n_q;
      rst_n_clr[top_idx] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_HOLD;
         rst_n_q <= '0;
         stage_q <= '0;
         done_q  <= 1'b0;
         skip_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         rst_n_q <= rst_n_d;
         stage_q <= stage_d;
         done_q  <= done_d;
         skip_q  <= skip_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HOLD:   if (hold_exp) state_d = ST_WAIT;
         ST_WAIT: begin
            if (req_i)    state_d = ST_ASSERT;
            else if (adv) state_d = is_last ? ST_RUN : ST_DELAY;
         end
         ST_DELAY: begin
            if (req_i)        state_d = ST_ASSERT;
            else if (cnt_exp) state_d = ST_WAIT;
         end
         ST_RUN:    if (req_i) state_d = ST_ASSERT;
         ST_ASSERT: if (rst_n_clr == '0) state_d = ST_HOLD;
         default:   state_d = ST_HOLD;
      endcase
   end

   always_comb begin
      rst_n_d  = rst_n_q;
      stage_d  = stage_q;
      done_d   = (state_q == ST_RUN);
      skip_d   = 1'b0;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      cnt_val  = CNT_W'(H_HOLD);
      case (state_q)
         ST_HOLD: begin
            cnt_en = ~skip_q;
            if (hold_exp) begin
               rst_n_d[0] = 1'b1;
               stage_d    = '0;
            end
         end
         ST_WAIT: begin
            if (!req_i && adv && !is_last) begin
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(D_DELAY);
            end
         end
         ST_DELAY: begin
            cnt_en = 1'b1;
            if (!req_i && cnt_exp) begin
               rst_n_d[stage_nxt] = 1'b1;
               stage_d            = stage_nxt;
            end
         end
         ST_ASSERT: begin
            rst_n_d = rst_n_clr;
            stage_d = top_idx;
            if (rst_n_clr == '0) cnt_load = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef RST_SEQ_TIMEOUT_EN
   logic wait_entry, tmo_exp, err_q, err_d;

   assign wait_entry = (state_q == ST_HOLD  && hold_exp) ||
                       (state_q == ST_DELAY && !req_i && cnt_exp);
   assign tmo_hit    = (state_q == ST_WAIT) & tmo_exp;
   assign err_d      = err_q | (tmo_hit & ~req_i);

   cnt_dn #(.W(CNT_W), .RST_VAL(T_TIMEOUT)) u_tmo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (wait_entry),
      .en_i   (state_q == ST_WAIT),
      .val_i  (CNT_W'(T_TIMEOUT)),
      .exp_o  (tmo_exp)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign err_o = err_q;
`else
   assign tmo_hit = 1'b0;
   assign err_o   = 1'b0;
`endif

   assign rst_n_o = rst_n_q;
   assign done_o  = done_q;
   assign stage_o = stage_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboarded bench for rst_seq: expected output snapshots are queued per scenario and checked at their cycle.
module tb_rst_seq;

   localparam int unsigned N = 4;

   logic         clk;
   logic         rst_i, req_i;
   logic [N-1:0] rdy_i;
   logic [N-1:0] rst_n_o;
   logic         done_o;
   logic [1:0]   stage_o;
   logic         err_o;

   typedef struct {
      int         cyc;
      logic [3:0] rn;
      logic       dn;
      logic [1:0] st;
      logic       er;
   } exp_t;

   exp_t       sb[$];
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;
   int         t0;
   logic [3:0] auto_en;
   int         age[N];

   rst_seq #(.N_DOMAIN(4), .H_HOLD(8), .D_DELAY(16), .T_TIMEOUT(32)) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .req_i   (req_i),
      .rdy_i   (rdy_i),
      .rst_n_o (rst_n_o),
      .done_o  (done_o),
      .stage_o (stage_o),
      .err_o   (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; domains raise ready 2 cycles after release and drop it when reset.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < N; k++) begin
         if (rst_n_o[k] !== 1'b1) begin
            age[k]   = 0;
            rdy_i[k] = 1'b0;
         end else begin
            age[k]++;
            if (age[k] >= 2 && auto_en[k]) rdy_i[k] = 1'b1;
         end
      end
   endtask

   task automatic push(input int c, input logic [3:0] rn, input logic dn,
                       input logic [1:0] st, input logic er);
      exp_t e;
      e.cyc = c; e.rn = rn; e.dn = dn; e.st = st; e.er = er;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      rst_i = 1'b1; req_i = 1'b0; rdy_i = '0; auto_en = 4'hF;
      for (int k = 0; k < N; k++) age[k] = 0;
      repeat (3) tick();
      n_tests++;
      if (rst_n_o !== 4'b0000) begin n_fail++; $display("FAIL reset rst_n_o: got %b, required 0000", rst_n_o); end
      n_tests++;
      if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset done_o: got %b, required 0", done_o); end
      n_tests++;
      if (stage_o !== 2'd0) begin n_fail++; $display("FAIL reset stage_o: got %0d, required 0", stage_o); end
      n_tests++;
      if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset err_o: got %b, required 0", err_o); end
      rst_i = 1'b0;
      t0 = cyc + 1;
   endtask

   task automatic test_power_up();
      exp_t e;
      int   e0 = t0;
      push(e0 + 7,  4'b0000, 0, 0, 0);
      push(e0 + 8,  4'b0001, 0, 0, 0);
      push(e0 + 25, 4'b0001, 0, 0, 0);
      push(e0 + 26, 4'b0011, 0, 1, 0);
      push(e0 + 43, 4'b0011, 0, 1, 0);
      push(e0 + 44, 4'b0111, 0, 2, 0);
      push(e0 + 62, 4'b1111, 0, 3, 0);
      push(e0 + 64, 4'b1111, 0, 3, 0);
      push(e0 + 65, 4'b1111, 1, 3, 0);
      while (cyc < e0 + 68) begin
         tick();
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front(); n_tests++;
            if ({rst_n_o, done_o, stage_o, err_o} !== {e.rn, e.dn, e.st, e.er}) begin
               n_fail++;
               $display("FAIL power_up @%0d: rst_n=%b done=%b stage=%0d err=%b, required rst_n=%b done=%b stage=%0d err=%b",
                        cyc, rst_n_o, done_o, stage_o, err_o, e.rn, e.dn, e.st, e.er);
            end
         end
      end
   endtask

   task automatic test_soft_reset();
      exp_t e;
      int   r = cyc + 1;
      push(r,      4'b1111, 1, 3, 0);
      push(r + 1,  4'b0111, 0, 3, 0);
      push(r + 2,  4'b0011, 0, 2, 0);
      push(r + 3,  4'b0001, 0, 1, 0);
      push(r + 4,  4'b0000, 0, 0, 0);
      push(r + 11, 4'b0000, 0, 0, 0);
      push(r + 12, 4'b0001, 0, 0, 0);
      push(r + 30, 4'b0011, 0, 1, 0);
      push(r + 48, 4'b0111, 0, 2, 0);
      push(r + 66, 4'b1111, 0, 3, 0);
      push(r + 68, 4'b1111, 0, 3, 0);
      push(r + 69, 4'b1111, 1, 3, 0);
      while (cyc < r + 70) begin
         req_i = (cyc + 1 == r);
         tick();
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front(); n_tests++;
            if ({rst_n_o, done_o, stage_o, err_o} !== {e.rn, e.dn, e.st, e.er}) begin
               n_fail++;
               $display("FAIL soft_reset @%0d: rst_n=%b done=%b stage=%0d err=%b, required rst_n=%b done=%b stage=%0d err=%b",
                        cyc, rst_n_o, done_o, stage_o, err_o, e.rn, e.dn, e.st, e.er);
            end
         end
      end
      req_i = 1'b0;
   endtask

   task automatic test_req_in_delay();
      exp_t e;
      int   s = cyc + 1;
      int   q = s + 40;
      logic early = 1'b0;
      push(s + 4,  4'b0000, 0, 0, 0);
      push(s + 30, 4'b0011, 0, 1, 0);
      push(q,      4'b0011, 0, 1, 0);
      push(q + 1,  4'b0001, 0, 1, 0);
      push(q + 2,  4'b0000, 0, 0, 0);
      push(q + 9,  4'b0000, 0, 0, 0);
      push(q + 10, 4'b0001, 0, 0, 0);
      while (cyc < q + 12) begin
         req_i = (cyc + 1 == s) || (cyc + 1 == q);
         tick();
         if (cyc >= q && rst_n_o[2] !== 1'b0) early = 1'b1;
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front(); n_tests++;
            if ({rst_n_o, done_o, stage_o, err_o} !== {e.rn, e.dn, e.st, e.er}) begin
               n_fail++;
               $display("FAIL req_in_delay @%0d: rst_n=%b done=%b stage=%0d err=%b, required rst_n=%b done=%b stage=%0d err=%b",
                        cyc, rst_n_o, done_o, stage_o, err_o, e.rn, e.dn, e.st, e.er);
            end
         end
      end
      req_i = 1'b0;
      n_tests++;
      if (early !== 1'b0) begin n_fail++; $display("FAIL req_in_delay stage2_release: got %b, required 0", early); end
      t0 = q + 10;
   endtask

   task automatic test_rst_pulse();
      exp_t e;
      int   a = t0;
      int   p = a + 40;
      push(a + 36, 4'b0111, 0, 2, 0);
      push(p - 1,  4'b0111, 0, 2, 0);
      push(p,      4'b0000, 0, 0, 0);
      push(p + 8,  4'b0000, 0, 0, 0);
      push(p + 9,  4'b0001, 0, 0, 0);
      while (cyc < p + 10) begin
         rst_i = (cyc + 1 == p);
         tick();
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front(); n_tests++;
            if ({rst_n_o, done_o, stage_o, err_o} !== {e.rn, e.dn, e.st, e.er}) begin
               n_fail++;
               $display("FAIL rst_pulse @%0d: rst_n=%b done=%b stage=%0d err=%b, required rst_n=%b done=%b stage=%0d err=%b",
                        cyc, rst_n_o, done_o, stage_o, err_o, e.rn, e.dn, e.st, e.er);
            end
         end
      end
      rst_i = 1'b0;
      t0 = p + 9;
   endtask

   task automatic test_req_rdy_same();
      exp_t e;
      int   x = t0 + 18;
      logic rose = 1'b0;
      push(x,      4'b0011, 0, 1, 0);
      push(x + 2,  4'b0011, 0, 1, 0);
      push(x + 3,  4'b0001, 0, 1, 0);
      push(x + 4,  4'b0000, 0, 0, 0);
      push(x + 12, 4'b0001, 0, 0, 0);
      while (cyc < x + 14) begin
         req_i = (cyc + 1 == x + 2);
         tick();
         if (cyc >= x && rst_n_o[2] !== 1'b0) rose = 1'b1;
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front(); n_tests++;
            if ({rst_n_o, done_o, stage_o, err_o} !== {e.rn, e.dn, e.st, e.er}) begin
               n_fail++;
               $display("FAIL req_rdy_same @%0d: rst_n=%b done=%b stage=%0d err=%b, required rst_n=%b done=%b stage=%0d err=%b",
                        cyc, rst_n_o, done_o, stage_o, err_o, e.rn, e.dn, e.st, e.er);
            end
         end
      end
      req_i = 1'b0;
      n_tests++;
      if (rose !== 1'b0) begin n_fail++; $display("FAIL req_rdy_same stage2_release: got %b, required 0", rose); end
      t0 = x + 12;
   endtask

   task automatic test_timeout();
      exp_t e;
      int   y = t0 + 18;
      int   stop;
      auto_en[1] = 1'b0;
      push(y, 4'b0011, 0, 1, 0);
`ifdef RST_SEQ_TIMEOUT_EN
      push(y + 31, 4'b0011, 0, 1, 0);
      push(y + 32, 4'b0011, 0, 1, 1);
      push(y + 47, 4'b0011, 0, 1, 1);
      push(y + 48, 4'b0111, 0, 2, 1);
      stop = y + 50;
`else
      push(y + 32, 4'b0011, 0, 1, 0);
      push(y + 60, 4'b0011, 0, 1, 0);
      stop = y + 62;
`endif
      while (cyc < stop) begin
         tick();
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front(); n_tests++;
            if ({rst_n_o, done_o, stage_o, err_o} !== {e.rn, e.dn, e.st, e.er}) begin
               n_fail++;
               $display("FAIL timeout @%0d: rst_n=%b done=%b stage=%0d err=%b, required rst_n=%b done=%b stage=%0d err=%b",
                        cyc, rst_n_o, done_o, stage_o, err_o, e.rn, e.dn, e.st, e.er);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_soft_reset();
      test_req_in_delay();
      test_rst_pulse();
      test_req_rdy_same();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
